// File: rtl/pong_pkg.sv
// pong_pkg: constants and types shared by the Pong datapath blocks.
//   - GS_*  : 2-bit game_state bus codes (the ball engine moves only on GS_PLAY)
//   - WIN_* : winner codes reported to the display logic
//   - H_ACTIVE / V_ACTIVE : visible raster size
//   - ctrl_state_e / state_to_gs : game_ctrl internal states and their bus encoding
package pong_pkg;

  localparam logic [1:0] GS_IDLE = 2'b00;
  localparam logic [1:0] GS_PLAY = 2'b01;
  localparam logic [1:0] GS_HOLD = 2'b10;
  localparam logic [1:0] GS_OVER = 2'b11;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_OVER  = 3'd4
  } ctrl_state_e;

  // Serve delay and pause share the HOLD code; the side flags tell them apart.
  function automatic logic [1:0] state_to_gs(input ctrl_state_e s);
    case (s)
      S_PLAY:          return GS_PLAY;
      S_SERVE, S_PAUSE: return GS_HOLD;
      S_OVER:          return GS_OVER;
      default:         return GS_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: conditions one raw, asynchronous, active-high push button.
//   2-flop synchronizer -> stability counter -> rising-edge pulse.
// Parameters:
//   DEBOUNCE_MS : consecutive equal samples needed before the level changes (1-255)
// Ports:
//   clk_1ms : 1 ms tick clock
//   reset   : synchronous, active-low
//   btn_i   : raw button
//   rise_o  : one-tick pulse on the rising edge of the debounced level
// Press-to-pulse latency is 2 + DEBOUNCE_MS ticks.
module btn_debounce #(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk_1ms,
  input  logic reset,
  input  logic btn_i,
  output logic rise_o
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_MS - 1);

  logic [1:0] sync_q;
  logic       level_q, level_d;
  logic [7:0] cnt_q, cnt_d;
  logic       rise_q, rise_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = 8'd0;
    rise_d  = 1'b0;
    // Any sample agreeing with the current level restarts the count, so only
    // an unbroken run of DEBOUNCE_MS differing samples flips the level.
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
        rise_d  = sync_q[1];
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_1ms) begin
    if (!reset) begin
      sync_q  <= 2'b00;
      level_q <= 1'b0;
      cnt_q   <= 8'd0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: match-level controller for the Pong datapath.
//   idle -> serve delay -> play -> (point) -> serve delay -> ... -> game over
// Parameters:
//   WIN_SCORE      : score (1-15) at which a player wins
//   SERVE_DELAY_MS : ticks spent in serve hold (1-65535)
//   DEBOUNCE_MS    : button stability time in ticks (1-255)
// Ports:
//   clk_1ms    : 1 ms tick clock
//   reset      : synchronous, active-low
//   start_btn  : raw start button
//   pause_btn  : raw pause button (used only when GAME_CTRL_PAUSE_EN is defined)
//   p1_score   : player-1 score from the ball engine
//   p2_score   : player-2 score from the ball engine
//   game_state : 00 idle, 01 play, 10 hold, 11 over
//   serving    : hold due to serve delay
//   paused     : hold due to pause
//   winner     : 00 none, 01 P1, 10 P2, 11 tie
// Build option: define GAME_CTRL_PAUSE_EN to enable the pause path.
module game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE      = 9,
  parameter int SERVE_DELAY_MS = 1000,
  parameter int DEBOUNCE_MS    = 20
) (
  input  logic       clk_1ms,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic [3:0] p1_score,
  input  logic [3:0] p2_score,
  output logic [1:0] game_state,
  output logic       serving,
  output logic       paused,
  output logic [1:0] winner
);

  localparam logic [3:0]  WIN_Q      = 4'(WIN_SCORE);
  localparam logic [15:0] SERVE_LOAD = 16'(SERVE_DELAY_MS - 1);

  ctrl_state_e state_q, state_d;
  logic [15:0] serve_cnt_q, serve_cnt_d;
  logic [3:0]  prev1_q, prev2_q;
  logic [1:0]  winner_q, winner_d;

  logic start_p, pause_p;
  logic point, p1_win, p2_win;

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_start_db (
    .clk_1ms (clk_1ms),
    .reset   (reset),
    .btn_i   (start_btn),
    .rise_o  (start_p)
  );

`ifdef GAME_CTRL_PAUSE_EN
  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_pause_db (
    .clk_1ms (clk_1ms),
    .reset   (reset),
    .btn_i   (pause_btn),
    .rise_o  (pause_p)
  );
`else
  logic unused_pause_btn;
  assign unused_pause_btn = pause_btn;
  assign pause_p          = 1'b0;
`endif

  // A point is any change of either score since the previous tick.
  assign point  = (p1_score != prev1_q) || (p2_score != prev2_q);
  assign p1_win = (p1_score >= WIN_Q);
  assign p2_win = (p2_score >= WIN_Q);

  always_comb begin
    state_d     = state_q;
    serve_cnt_d = serve_cnt_q;
    winner_d    = winner_q;
    case (state_q)
      S_IDLE: begin
        if (start_p) begin
          state_d     = S_SERVE;
          serve_cnt_d = SERVE_LOAD;
        end
      end
      S_SERVE: begin
        if (serve_cnt_q == 16'd0) begin
          state_d = S_PLAY;
        end else begin
          serve_cnt_d = serve_cnt_q - 16'd1;
        end
      end
      S_PLAY: begin
        // A point in the same tick as a pause press wins.
        if (point) begin
          if (p1_win || p2_win) begin
            state_d  = S_OVER;
            winner_d = {p2_win, p1_win};
          end else begin
            state_d     = S_SERVE;
            serve_cnt_d = SERVE_LOAD;
          end
        end else if (pause_p) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (pause_p) begin
          state_d = S_PLAY;
        end
      end
      S_OVER: begin
        state_d = S_OVER;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_1ms) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      serve_cnt_q <= 16'd0;
      prev1_q     <= 4'd0;
      prev2_q     <= 4'd0;
      winner_q    <= WIN_NONE;
    end else begin
      state_q     <= state_d;
      serve_cnt_q <= serve_cnt_d;
      // Scores are tracked in every state so that changes made outside play
      // never show up later as a spurious point.
      prev1_q     <= p1_score;
      prev2_q     <= p2_score;
      winner_q    <= winner_d;
    end
  end

  assign game_state = state_to_gs(state_q);
  assign serving    = (state_q == S_SERVE);
  assign winner     = winner_q;
`ifdef GAME_CTRL_PAUSE_EN
  assign paused     = (state_q == S_PAUSE);
`else
  assign paused     = 1'b0;
`endif

endmodule
